threshold_alarm_fsm: RTL and testbench
======================================

Name: threshold_alarm_fsm

Overview:
- Sequential consumer of n-bit magnitude comparisons (less / greater / equal).
- Each valid sample is compared against a programmable high and low threshold.
- Exceedances are debounced over DEB consecutive samples, and the resulting high/low alarms are held with symmetric release debouncing.
- Per-direction alarm events are counted for status readout.

Parameters:
- n, 32, data and threshold width.
- DEB, 3, number of consecutive qualifying samples to enter or release an alarm (>=1).
- CW, 8, width of each saturating event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  data is a new sample this cycle.
- data  input  n  unsigned sample.
- thr_hi  input  n  unsigned high threshold; sampled with data.
- thr_lo  input  n  unsigned low threshold; sampled with data.
- cnt_clr  input  1  synchronous clear of both event counters.
- alarm_hi  output  1  high alarm active.
- alarm_lo  output  1  low alarm active.
- state  output  3  FSM state encoding, listed under Behaviour.
- hi_events  output  CW  number of high-alarm entries, saturating.
- lo_events  output  CW  number of low-alarm entries, saturating.
- out_valid  output  1  one-cycle pulse, high the cycle after each accepted sample.

Behaviour:
- One clock domain. Reset is asynchronous, active-high.
- Reset values:
  - state = NORMAL (0), debounce counter = 0.
  - alarm_hi = alarm_lo = 0, hi_events = lo_events = 0, out_valid = 0.
- Classification, unsigned:
  - HI when data > thr_hi (strictly greater).
  - LO when data < thr_lo (strictly less).
  - Otherwise IN; equality with either threshold counts as IN.
  - If a sample is both HI and LO (thr_lo > thr_hi), HI wins.
- FSM state encodings: NORMAL=0, PEND_HI=1, ALARM_HI=2, PEND_LO=3, ALARM_LO=4. Values 5-7 recover to NORMAL on the next edge.
- The FSM advances only on clock edges with in_valid=1. When in_valid=0, the state, counter and alarms hold.
- Internal debounce counter is $clog2(DEB+1) bits wide.
- NORMAL:
  - HI: go to PEND_HI with cnt=1.
  - LO: go to PEND_LO with cnt=1.
  - IN: stay, cnt=0.
  - If DEB==1, HI goes directly to ALARM_HI and LO directly to ALARM_LO, each with cnt=0.
- PEND_HI:
  - HI: cnt+1. When the new cnt equals DEB, go to ALARM_HI with cnt=0.
  - LO: go to PEND_LO with cnt=1.
  - IN: go to NORMAL with cnt=0.
- ALARM_HI:
  - HI: cnt=0.
  - Non-HI (IN or LO): cnt+1. When the new cnt equals DEB, go to NORMAL with cnt=0.
  - A LO sample never moves directly from ALARM_HI to any LO state.
- PEND_LO and ALARM_LO mirror PEND_HI and ALARM_HI with HI and LO swapped.
- Outputs are registered:
  - alarm_hi = (state==ALARM_HI).
  - alarm_lo = (state==ALARM_LO).
  - Both alarms change on the edge that enters or leaves the alarm state. Latency from the DEB-th qualifying sample edge is 0 extra cycles.
- Event counters:
  - hi_events increments on the edge that enters ALARM_HI; lo_events likewise on entry to ALARM_LO.
  - Both saturate at 2^CW-1.
  - cnt_clr has priority: a coincident entry event is not counted, so the counter reads 0.
  - cnt_clr does not affect the FSM.
- out_valid is a registered copy of in_valid.
- Threshold changes take effect on the next valid sample. There is no retroactive re-evaluation.
- Reset mid-alarm clears everything immediately, asynchronously.

Test Plan:
- Setup for every scenario: n=8, DEB=3, thr_hi=200, thr_lo=50.
- Reset, then samples 100,120 -> state stays 0, alarms 0, out_valid pulses once per sample, counters 0.
- Samples 201,210,250 back-to-back -> state 1,1,2. alarm_hi rises after the 3rd edge; hi_events=1.
- In ALARM_HI, samples 100,100,220,100,100,100 -> alarm_hi stays 1 through the 220 (counter restart). Returns to NORMAL after the final 100; alarm_hi=0.
- Samples 201,202,200 -> the 200 is IN (equal), so state returns to NORMAL with no alarm. Samples 49,30 then 201 -> PEND_LO then PEND_HI with cnt=1; no alarm.
- Samples 10,10,10 with in_valid gaps of 4 idle cycles between them -> alarm_lo asserts after the 3rd valid sample. State holds during the gaps; lo_events=1.
- Two further cases:
  - Assert rst asynchronously mid-ALARM_LO -> all outputs 0 before the next edge.
  - Force hi_events to 255, then a new alarm entry -> stays 255. cnt_clr coincident with an entry -> 0.

Source files
------------

// File: rtl/threshold_alarm_fsm.sv
// Debounced high/low threshold alarm FSM with registered alarms and
// saturating per-direction alarm-entry counters.
module threshold_alarm_fsm #(
    parameter int n   = 32,
    parameter int DEB = 3,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [n-1:0]  data,
    input  logic [n-1:0]  thr_hi,
    input  logic [n-1:0]  thr_lo,
    input  logic          cnt_clr,
    output logic          alarm_hi,
    output logic          alarm_lo,
    output logic [2:0]    state,
    output logic [CW-1:0] hi_events,
    output logic [CW-1:0] lo_events,
    output logic          out_valid
);
    localparam int CNTW = $clog2(DEB + 1);
    localparam logic [CNTW-1:0] DEB_C = CNTW'(DEB);
    localparam logic [CNTW-1:0] ONE_C = CNTW'(1);

    localparam logic [2:0] S_NORMAL   = 3'd0;
    localparam logic [2:0] S_PEND_HI  = 3'd1;
    localparam logic [2:0] S_ALARM_HI = 3'd2;
    localparam logic [2:0] S_PEND_LO  = 3'd3;
    localparam logic [2:0] S_ALARM_LO = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            alarm_hi_q, alarm_lo_q, out_valid_q;
    logic [CW-1:0]   hi_events_q, lo_events_q;
    logic            is_hi, is_lo, enter_hi, enter_lo;

    // HI takes precedence when the thresholds are inverted.
    assign is_hi   = data > thr_hi;
    assign is_lo   = !is_hi && (data < thr_lo);
    assign cnt_inc = cnt_q + ONE_C;

    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q > S_ALARM_LO) begin
            state_d = S_NORMAL;
            cnt_d   = '0;
        end else if (in_valid) begin
            case (state_q)
                S_NORMAL: begin
                    if (is_hi) begin
                        state_d = (DEB == 1) ? S_ALARM_HI : S_PEND_HI;
                        cnt_d   = (DEB == 1) ? '0 : ONE_C;
                    end else if (is_lo) begin
                        state_d = (DEB == 1) ? S_ALARM_LO : S_PEND_LO;
                        cnt_d   = (DEB == 1) ? '0 : ONE_C;
                    end else begin
                        cnt_d = '0;
                    end
                end
                S_PEND_HI: begin
                    if (is_hi) begin
                        state_d = (cnt_inc == DEB_C) ? S_ALARM_HI : S_PEND_HI;
                        cnt_d   = (cnt_inc == DEB_C) ? '0 : cnt_inc;
                    end else if (is_lo) begin
                        state_d = S_PEND_LO;
                        cnt_d   = ONE_C;
                    end else begin
                        state_d = S_NORMAL;
                        cnt_d   = '0;
                    end
                end
                S_ALARM_HI: begin
                    if (is_hi) begin
                        cnt_d = '0;
                    end else begin
                        state_d = (cnt_inc == DEB_C) ? S_NORMAL : S_ALARM_HI;
                        cnt_d   = (cnt_inc == DEB_C) ? '0 : cnt_inc;
                    end
                end
                S_PEND_LO: begin
                    if (is_lo) begin
                        state_d = (cnt_inc == DEB_C) ? S_ALARM_LO : S_PEND_LO;
                        cnt_d   = (cnt_inc == DEB_C) ? '0 : cnt_inc;
                    end else if (is_hi) begin
                        state_d = S_PEND_HI;
                        cnt_d   = ONE_C;
                    end else begin
                        state_d = S_NORMAL;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    // ALARM_LO: only LO samples restart the release count.
                    if (is_lo) begin
                        cnt_d = '0;
                    end else begin
                        state_d = (cnt_inc == DEB_C) ? S_NORMAL : S_ALARM_LO;
                        cnt_d   = (cnt_inc == DEB_C) ? '0 : cnt_inc;
                    end
                end
            endcase
        end
    end

    assign enter_hi = (state_d == S_ALARM_HI) && (state_q != S_ALARM_HI);
    assign enter_lo = (state_d == S_ALARM_LO) && (state_q != S_ALARM_LO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_NORMAL;
            cnt_q       <= '0;
            alarm_hi_q  <= 1'b0;
            alarm_lo_q  <= 1'b0;
            out_valid_q <= 1'b0;
            hi_events_q <= '0;
            lo_events_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alarm_hi_q  <= (state_d == S_ALARM_HI);
            alarm_lo_q  <= (state_d == S_ALARM_LO);
            out_valid_q <= in_valid;
            if (cnt_clr) begin
                hi_events_q <= '0;
                lo_events_q <= '0;
            end else begin
                if (enter_hi && (hi_events_q != '1)) hi_events_q <= hi_events_q + CW'(1);
                if (enter_lo && (lo_events_q != '1)) lo_events_q <= lo_events_q + CW'(1);
            end
        end
    end

    assign state     = state_q;
    assign alarm_hi  = alarm_hi_q;
    assign alarm_lo  = alarm_lo_q;
    assign out_valid = out_valid_q;
    assign hi_events = hi_events_q;
    assign lo_events = lo_events_q;

endmodule

// File: tb/tb_threshold_alarm_fsm.sv
// Self-checking bench for threshold_alarm_fsm: directed scenarios plus randomized
// samples checked against a history-based model of the debounce rules.
module tb_threshold_alarm_fsm;
    localparam int N   = 8;
    localparam int DEB = 3;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    typedef enum int {C_IN, C_HI, C_LO} cls_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [N-1:0]  data;
    logic [N-1:0]  thr_hi;
    logic [N-1:0]  thr_lo;
    logic          cnt_clr;
    logic          alarm_hi;
    logic          alarm_lo;
    logic [2:0]    state;
    logic [CW-1:0] hi_events;
    logic [CW-1:0] lo_events;
    logic          out_valid;

    threshold_alarm_fsm #(.n(N), .DEB(DEB), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .data     (data),
        .thr_hi   (thr_hi),
        .thr_lo   (thr_lo),
        .cnt_clr  (cnt_clr),
        .alarm_hi (alarm_hi),
        .alarm_lo (alarm_lo),
        .state    (state),
        .hi_events(hi_events),
        .lo_events(lo_events),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: current alarm (0 none, 1 high, 2 low) plus the classifications seen
    // since the last alarm change or in-band sample.
    int     m_mode;
    cls_t   m_hist[$];
    int     m_hi_ev;
    int     m_lo_ev;
    logic   m_ov;

    function automatic cls_t classify(input logic [N-1:0] d, input logic [N-1:0] hi,
                                      input logic [N-1:0] lo);
        if (d > hi) return C_HI;
        if (d < lo) return C_LO;
        return C_IN;
    endfunction

    // Length of the most recent run of samples that are (same=1) or are not (same=0) class c.
    function automatic int trailing(input cls_t c, input bit same);
        int k = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if ((m_hist[i] == c) != same) break;
            k++;
        end
        return k;
    endfunction

    function automatic logic [2:0] exp_state();
        if (m_mode == 1) return 3'd2;
        if (m_mode == 2) return 3'd4;
        if (m_hist.size() == 0) return 3'd0;
        return (m_hist[$] == C_HI) ? 3'd1 : 3'd3;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_hist.delete();
        m_hi_ev = 0;
        m_lo_ev = 0;
        m_ov = 1'b0;
    endtask

    task automatic model_sample(input logic [N-1:0] d, input logic clr);
        cls_t c;
        bit   ent_hi;
        bit   ent_lo;
        c = classify(d, thr_hi, thr_lo);
        ent_hi = 1'b0;
        ent_lo = 1'b0;
        m_hist.push_back(c);
        if (m_mode == 0) begin
            if (c == C_IN) begin
                m_hist.delete();
            end else if (trailing(c, 1'b1) == DEB) begin
                m_mode = (c == C_HI) ? 1 : 2;
                ent_hi = (c == C_HI);
                ent_lo = (c == C_LO);
                m_hist.delete();
            end
        end else if (trailing((m_mode == 1) ? C_HI : C_LO, 1'b0) == DEB) begin
            m_mode = 0;
            m_hist.delete();
        end
        if (clr) begin
            m_hi_ev = 0;
            m_lo_ev = 0;
        end else begin
            if (ent_hi && m_hi_ev < SAT) m_hi_ev++;
            if (ent_lo && m_lo_ev < SAT) m_lo_ev++;
        end
    endtask

    // One clock: drive at the falling edge, observe 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [N-1:0] d, input logic clr);
        @(negedge clk);
        in_valid = v;
        data     = d;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
        if (v) model_sample(d, clr);
        else if (clr) begin
            m_hi_ev = 0;
            m_lo_ev = 0;
        end
        m_ov = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        data = '0;
        cnt_clr = 1'b0;
        thr_hi = 8'd200;
        thr_lo = 8'd50;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({state, alarm_hi, alarm_lo, hi_events, lo_events, out_valid} !== '0) begin
            n_bad++;
            $display("FAIL reset: state=%0d ahi=%b alo=%b hev=%0d lev=%0d ov=%b, expected all 0",
                     state, alarm_hi, alarm_lo, hi_events, lo_events, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_in_band();
        logic [N-1:0] seq [2] = '{8'd100, 8'd120};
        for (int i = 0; i < 2; i++) begin
            step(1'b1, seq[i], 1'b0);
            n_cmp++;
            if (state !== 3'd0 || alarm_hi !== 1'b0 || alarm_lo !== 1'b0 || out_valid !== 1'b1 ||
                hi_events !== '0 || lo_events !== '0) begin
                n_bad++;
                $display("FAIL in_band[%0d]: state=%0d ahi=%b alo=%b ov=%b hev=%0d lev=%0d, expected 0 0 0 1 0 0",
                         i, state, alarm_hi, alarm_lo, out_valid, hi_events, lo_events);
            end
            step(1'b0, 8'd0, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL in_band_pulse[%0d]: out_valid=%b, expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_hi_entry();
        logic [N-1:0] seq [3]    = '{8'd201, 8'd210, 8'd250};
        logic [2:0]   exp_st [3] = '{3'd1, 3'd1, 3'd2};
        logic         exp_a [3]  = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq[i], 1'b0);
            n_cmp++;
            if (state !== exp_st[i] || alarm_hi !== exp_a[i]) begin
                n_bad++;
                $display("FAIL hi_entry[%0d]: state=%0d alarm_hi=%b, expected %0d %b",
                         i, state, alarm_hi, exp_st[i], exp_a[i]);
            end
        end
        n_cmp++;
        if (hi_events !== 8'd1 || lo_events !== 8'd0) begin
            n_bad++;
            $display("FAIL hi_entry_events: hev=%0d lev=%0d, expected 1 0", hi_events, lo_events);
        end
    endtask

    task automatic test_hi_release();
        logic [N-1:0] seq [6]    = '{8'd100, 8'd100, 8'd220, 8'd100, 8'd100, 8'd100};
        logic [2:0]   exp_st [6] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq[i], 1'b0);
            n_cmp++;
            if (state !== exp_st[i] || alarm_hi !== (exp_st[i] == 3'd2)) begin
                n_bad++;
                $display("FAIL hi_release[%0d]: state=%0d alarm_hi=%b, expected %0d %b",
                         i, state, alarm_hi, exp_st[i], exp_st[i] == 3'd2);
            end
        end
    endtask

    task automatic test_equal_and_switch();
        logic [N-1:0] seq [7]    = '{8'd201, 8'd202, 8'd200, 8'd49, 8'd30, 8'd201, 8'd100};
        logic [2:0]   exp_st [7] = '{3'd1, 3'd1, 3'd0, 3'd3, 3'd3, 3'd1, 3'd0};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq[i], 1'b0);
            n_cmp++;
            if (state !== exp_st[i] || alarm_hi !== 1'b0 || alarm_lo !== 1'b0) begin
                n_bad++;
                $display("FAIL equal_switch[%0d]: state=%0d ahi=%b alo=%b, expected %0d 0 0",
                         i, state, alarm_hi, alarm_lo, exp_st[i]);
            end
        end
    endtask

    task automatic test_lo_gaps();
        logic [2:0] exp_st [3] = '{3'd3, 3'd3, 3'd4};
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'd10, 1'b0);
            n_cmp++;
            if (state !== exp_st[k] || alarm_lo !== (k == 2) || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL lo_gaps[%0d]: state=%0d alarm_lo=%b ov=%b, expected %0d %b 1",
                         k, state, alarm_lo, out_valid, exp_st[k], k == 2);
            end
            if (k < 2) begin
                for (int g = 0; g < 4; g++) begin
                    step(1'b0, 8'd10, 1'b0);
                    n_cmp++;
                    if (state !== exp_st[k] || out_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL lo_gap_hold[%0d.%0d]: state=%0d ov=%b, expected %0d 0",
                                 k, g, state, out_valid, exp_st[k]);
                    end
                end
            end
        end
        n_cmp++;
        if (lo_events !== 8'd1) begin
            n_bad++;
            $display("FAIL lo_gaps_events: lo_events=%0d, expected 1", lo_events);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        n_cmp++;
        if (state !== 3'd4 || alarm_lo !== 1'b1) begin
            n_bad++;
            $display("FAIL async_pre: state=%0d alarm_lo=%b, expected 4 1", state, alarm_lo);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({state, alarm_hi, alarm_lo, hi_events, lo_events, out_valid} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: state=%0d ahi=%b alo=%b hev=%0d lev=%0d ov=%b, expected all 0",
                     state, alarm_hi, alarm_lo, hi_events, lo_events, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        cnt_clr = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_saturation();
        for (int e = 0; e < SAT; e++) begin
            repeat (3) step(1'b1, 8'd250, 1'b0);
            repeat (3) step(1'b1, 8'd100, 1'b0);
        end
        n_cmp++;
        if (hi_events !== 8'd255 || state !== 3'd0) begin
            n_bad++;
            $display("FAIL sat_fill: hi_events=%0d state=%0d, expected 255 0", hi_events, state);
        end
        repeat (3) step(1'b1, 8'd250, 1'b0);
        n_cmp++;
        if (hi_events !== 8'd255 || alarm_hi !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_hold: hi_events=%0d alarm_hi=%b, expected 255 1", hi_events, alarm_hi);
        end
        repeat (3) step(1'b1, 8'd100, 1'b0);
        repeat (2) step(1'b1, 8'd250, 1'b0);
        step(1'b1, 8'd250, 1'b1);
        n_cmp++;
        if (hi_events !== 8'd0 || lo_events !== 8'd0 || alarm_hi !== 1'b1 || state !== 3'd2) begin
            n_bad++;
            $display("FAIL clr_priority: hev=%0d lev=%0d ahi=%b state=%0d, expected 0 0 1 2",
                     hi_events, lo_events, alarm_hi, state);
        end
    endtask

    task automatic test_random();
        int           region;
        logic [N-1:0] d;
        logic         v;
        logic         clr;
        region = 2;
        d = 8'd100;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                thr_hi = N'($urandom_range(0, 255));
                thr_lo = N'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 3) == 0) region = int'($urandom_range(0, 3));
            case (region)
                0:       d = N'($urandom_range(thr_hi, 255));
                1:       d = N'($urandom_range(0, thr_lo));
                2:       d = N'($urandom_range(0, 255));
                default: d = (i % 2 == 1) ? thr_hi : thr_lo;
            endcase
            v   = ($urandom_range(0, 4) != 0);
            clr = ($urandom_range(0, 39) == 0);
            step(v, d, clr);
            n_cmp++;
            if (state !== exp_state() || alarm_hi !== (m_mode == 1) || alarm_lo !== (m_mode == 2) ||
                hi_events !== CW'(m_hi_ev) || lo_events !== CW'(m_lo_ev) || out_valid !== m_ov) begin
                n_bad++;
                $display("FAIL random[%0d]: got st=%0d ahi=%b alo=%b hev=%0d lev=%0d ov=%b, expected st=%0d ahi=%b alo=%b hev=%0d lev=%0d ov=%b",
                         i, state, alarm_hi, alarm_lo, hi_events, lo_events, out_valid,
                         exp_state(), m_mode == 1, m_mode == 2, m_hi_ev, m_lo_ev, m_ov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_band();
        test_hi_entry();
        test_hi_release();
        test_equal_and_switch();
        test_lo_gaps();
        test_async_reset();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
